// File: rtl/rotl_serial_amisha.sv
// rotl_serial_amisha: multi-cycle rotator, one bit per clock.
// Takes a word and an amount over a valid/ready input handshake. Returns the
// rotated word over a valid/ready output handshake.
// Optional macro ROT_DIR_SEL_EN adds a dir_amisha input: 0 = left, 1 = right.
// With the macro undefined the unit rotates left only.
module rotl_serial_amisha #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = 3
) (
    input  logic             clk_amisha,
    input  logic             reset_amisha,
    input  logic             in_valid_amisha,
    output logic             in_ready_amisha,
    input  logic [WIDTH-1:0] a_amisha,
    input  logic [AMT_W-1:0] amt_amisha,
`ifdef ROT_DIR_SEL_EN
    input  logic             dir_amisha,
`endif
    output logic [WIDTH-1:0] y_amisha,
    output logic             out_valid_amisha,
    input  logic             out_ready_amisha,
    output logic             busy_amisha
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
`ifdef ROT_DIR_SEL_EN
    logic             dir_q, dir_d;
`endif

    logic             accept;
    logic [WIDTH-1:0] data_rot;

    assign in_ready_amisha  = (state_q == IDLE) && !reset_amisha;
    assign accept           = in_valid_amisha && in_ready_amisha;
    assign out_valid_amisha = (state_q == DONE);
    assign busy_amisha      = (state_q != IDLE);
    // The working register also serves as the output register.
    // As a result, y holds its last value after the output handshake.
    assign y_amisha         = data_q;

    // One-bit rotation of the working register, in the selected direction.
    always_comb begin
`ifdef ROT_DIR_SEL_EN
        if (dir_q) begin
            data_rot = {data_q[0], data_q[WIDTH-1:1]};
        end else begin
            data_rot = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
        end
`else
        data_rot = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
`endif
    end

    // State, working data and counter registers with synchronous reset.
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
`ifdef ROT_DIR_SEL_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
`ifdef ROT_DIR_SEL_EN
            dir_q   <= dir_d;
`endif
        end
    end

    // Next-state logic: load on accept, rotate with countdown in SHIFT,
    // hold in DONE until the sink takes the result.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
`ifdef ROT_DIR_SEL_EN
        dir_d   = dir_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d = a_amisha;
                    cnt_d  = amt_amisha;
`ifdef ROT_DIR_SEL_EN
                    dir_d  = dir_amisha;
`endif
                    state_d = (amt_amisha == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d = data_rot;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_amisha) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
